// File: rtl/alu_decode_stage.sv
// ---------------------------------------------------------------------------
// alu_decode_stage
//   RV32I decode stage feeding an ALU/EX stage. Decodes the ALU subset of
//   RV32I (R-type ALU ops and I-type ALU immediates) into ALU operands, an
//   ALU op code, a destination register and a write enable. It presents them
//   through a one-entry registered output buffer with valid/ready flow control.
//   Decodes it does not support are flagged as illegal and counted.
//
// Configuration macro:
//   ALU_DEC_UTYPE_EN  when defined, LUI and AUIPC are decoded
//                     (LUI -> pass-b, AUIPC -> pc + imm); when undefined,
//                     they decode as illegal.
//
// Ports:
//   clk          sole clock, rising edge
//   rst          asynchronous active-high reset
//   in_valid     instruction/operands present        (input)
//   in_ready     stage can take an instruction        (output)
//   instr        RV32I instruction word               (input, 32)
//   pc           address of instr                     (input, 32)
//   rs1_data     register operand 1                   (input, 32)
//   rs2_data     register operand 2                   (input, 32)
//   flush        synchronous kill of held + incoming instruction
//   out_valid    registered result valid              (output)
//   out_ready    EX stage accepts the result          (input)
//   alu_a/alu_b  ALU operands                         (output, 32)
//   alu_op       0 add,1 sub,2 and,3 or,4 xor,5 sll,6 srl,7 sra,8 pass-b
//   rd           destination register index          (output, 5)
//   reg_write    result must be written to rd         (output)
//   illegal      instruction was not decodable        (output)
//   illegal_cnt  saturating count of accepted illegal instructions (output, 8)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds valid and payload stable until that edge.
// The stage accepts whenever its output buffer is empty, is being drained
// this cycle, or is being flushed. The registered payload never changes
// while out_valid is high and out_ready is low.
// ---------------------------------------------------------------------------
module alu_decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  output logic [4:0]  rd,
  output logic        reg_write,
  output logic        illegal,
  output logic [7:0]  illegal_cnt
);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_PASS = 4'b1000;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] shamt_i;
  logic [31:0] imm_u;

  assign opcode  = instr[6:0];
  assign funct3  = instr[14:12];
  assign funct7  = instr[31:25];
  assign imm_i   = {{20{instr[31]}}, instr[31:20]};
  assign shamt_i = {27'b0, instr[24:20]};
  assign imm_u   = {instr[31:12], 12'b0};

  // Register-index field rs1 is consumed upstream (operands arrive as data).
  logic unused_rs1_field;
  assign unused_rs1_field = ^instr[19:15];

  // -------------------------------------------------------------------------
  // Combinational decode. Operands are only driven inside legal branches, so
  // an illegal decode falls through to op=add, a=b=0.
  // -------------------------------------------------------------------------
  logic        dec_legal;
  logic [3:0]  dec_op;
  logic [31:0] dec_a;
  logic [31:0] dec_b;

  always_comb begin
    dec_legal = 1'b0;
    dec_op    = ALU_ADD;
    dec_a     = 32'b0;
    dec_b     = 32'b0;
    case (opcode)
      OPC_OP: begin
        if (funct7 == F7_BASE) begin
          dec_legal = 1'b1;
          case (funct3)
            3'b000:  dec_op = ALU_ADD;
            3'b001:  dec_op = ALU_SLL;
            3'b100:  dec_op = ALU_XOR;
            3'b101:  dec_op = ALU_SRL;
            3'b110:  dec_op = ALU_OR;
            3'b111:  dec_op = ALU_AND;
            default: dec_legal = 1'b0;  // slt, sltu
          endcase
        end else if (funct7 == F7_ALT) begin
          dec_legal = 1'b1;
          case (funct3)
            3'b000:  dec_op = ALU_SUB;
            3'b101:  dec_op = ALU_SRA;
            default: dec_legal = 1'b0;
          endcase
        end
        if (!dec_legal) begin
          dec_op = ALU_ADD;
        end else begin
          dec_a = rs1_data;
          dec_b = rs2_data;
        end
      end
      OPC_OP_IMM: begin
        dec_a = rs1_data;
        dec_b = imm_i;
        case (funct3)
          3'b000: begin dec_legal = 1'b1; dec_op = ALU_ADD; end
          3'b100: begin dec_legal = 1'b1; dec_op = ALU_XOR; end
          3'b110: begin dec_legal = 1'b1; dec_op = ALU_OR;  end
          3'b111: begin dec_legal = 1'b1; dec_op = ALU_AND; end
          3'b001: begin
            dec_b = shamt_i;
            if (funct7 == F7_BASE) begin
              dec_legal = 1'b1;
              dec_op    = ALU_SLL;
            end
          end
          3'b101: begin
            dec_b = shamt_i;
            if (funct7 == F7_BASE) begin
              dec_legal = 1'b1;
              dec_op    = ALU_SRL;
            end else if (funct7 == F7_ALT) begin
              dec_legal = 1'b1;
              dec_op    = ALU_SRA;
            end
          end
          default: dec_legal = 1'b0;  // slti, sltiu
        endcase
        if (!dec_legal) begin
          dec_op = ALU_ADD;
          dec_a  = 32'b0;
          dec_b  = 32'b0;
        end
      end
`ifdef ALU_DEC_UTYPE_EN
      OPC_LUI: begin
        dec_legal = 1'b1;
        dec_op    = ALU_PASS;
        dec_a     = 32'b0;
        dec_b     = imm_u;
      end
      OPC_AUIPC: begin
        dec_legal = 1'b1;
        dec_op    = ALU_ADD;
        dec_a     = pc;
        dec_b     = imm_u;
      end
`endif
      default: begin
        dec_legal = 1'b0;
      end
    endcase
  end

`ifndef ALU_DEC_UTYPE_EN
  // Without U-type support neither the pc nor the upper immediate is used.
  logic unused_utype;
  assign unused_utype = ^{pc, imm_u, OPC_LUI, OPC_AUIPC, ALU_PASS};
`endif

  // -------------------------------------------------------------------------
  // Flow control and output buffer
  // -------------------------------------------------------------------------
  logic accept;

  assign in_ready = !out_valid || out_ready || flush;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      alu_a       <= 32'b0;
      alu_b       <= 32'b0;
      alu_op      <= ALU_ADD;
      rd          <= 5'b0;
      reg_write   <= 1'b0;
      illegal     <= 1'b0;
      illegal_cnt <= 8'b0;
    end else if (flush) begin
      // Flush kills both the held result and any instruction arriving now;
      // the payload registers are left alone since out_valid masks them.
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      alu_a     <= dec_a;
      alu_b     <= dec_b;
      alu_op    <= dec_op;
      rd        <= instr[11:7];
      reg_write <= dec_legal && (instr[11:7] != 5'd0);
      illegal   <= !dec_legal;
      if (!dec_legal && (illegal_cnt != 8'hFF)) begin
        illegal_cnt <= illegal_cnt + 8'd1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_decode_stage
//   Self-checking bench for alu_decode_stage. A table of instructions with
//   hand-derived decode results is driven through the stage. Each accepted
//   instruction pushes its expected output record, and a monitor pops and
//   compares it when the stage hands the result downstream. Hand-written
//   sequences cover output hold under backpressure, illegal-count
//   saturation, flush and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_alu_decode_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [4:0]  rd;
  logic        reg_write;
  logic        illegal;
  logic [7:0]  illegal_cnt;

  alu_decode_stage dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instr       (instr),
    .pc          (pc),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .rd          (rd),
    .reg_write   (reg_write),
    .illegal     (illegal),
    .illegal_cnt (illegal_cnt)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- records and scoreboard ----------------
  localparam int W = 75;  // {illegal, op[3:0], a[31:0], b[31:0], rd[4:0], reg_write}

  typedef struct {
    logic [31:0]  instr;
    logic [31:0]  pc;
    logic [31:0]  rs1;
    logic [31:0]  rs2;
    logic [W-1:0] exp;
  } vec_t;

  vec_t         vecs[$];
  logic [W-1:0] exp_q[$];
  int           checks;
  int           fails;
  int           cnt_model;

  function automatic logic [W-1:0] pk(input logic ill, input logic [3:0] op,
                                      input logic [31:0] a, input logic [31:0] b,
                                      input logic [4:0] r, input logic rw);
    return {ill, op, a, b, r, rw};
  endfunction

  function automatic logic [W-1:0] actual();
    return {illegal, alu_op, alu_a, alu_b, rd, reg_write};
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic add_legal(input logic [31:0] i, input logic [31:0] p,
                           input logic [31:0] r1, input logic [31:0] r2,
                           input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] r);
    vec_t v;
    v.instr = i; v.pc = p; v.rs1 = r1; v.rs2 = r2;
    v.exp = pk(1'b0, op, a, b, r, (r != 5'd0));
    vecs.push_back(v);
  endtask

  task automatic add_illegal(input logic [31:0] i, input logic [31:0] p,
                             input logic [31:0] r1, input logic [31:0] r2,
                             input logic [4:0] r);
    vec_t v;
    v.instr = i; v.pc = p; v.rs1 = r1; v.rs2 = r2;
    v.exp = pk(1'b1, 4'h0, 32'h0, 32'h0, r, 1'b0);
    vecs.push_back(v);
  endtask

  // Monitor: the result is consumed on the next rising edge when valid and
  // ready are both high in the middle of the low phase.
  always @(negedge clk) begin
    #2;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL sb_unexpected: got %h required none", actual());
      end else begin
        chk("sb_out", actual(), exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  // rmode: 0 hold out_ready low, 1 hold it high, 2 randomise each cycle
  task automatic set_ready(input int rmode);
    if (rmode == 0)      out_ready = 1'b0;
    else if (rmode == 1) out_ready = 1'b1;
    else                 out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input vec_t v, input int rmode, input logic fl, output int waited);
    @(negedge clk);
    instr = v.instr; pc = v.pc; rs1_data = v.rs1; rs2_data = v.rs2;
    in_valid = 1'b1;
    flush = fl;
    set_ready(rmode);
    #1;
    waited = 0;
    while (!in_ready) begin
      if (waited >= 50) begin
        checks++;
        fails++;
        $display("FAIL accept_timeout: got in_ready=0 required 1 within 50 cycles");
        break;
      end
      @(negedge clk);
      set_ready(rmode);
      #1;
      waited++;
    end
    if (in_ready && !fl) begin
      exp_q.push_back(v.exp);
      if (v.exp[W-1] && cnt_model < 255) cnt_model++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    @(negedge clk);
    out_ready = 1'b1;
    while (exp_q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending required 0", exp_q.size());
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  // ---------------- test ----------------
  initial begin
    int   w;
    vec_t v;
    vec_t addv;
    vec_t sltv;
    vec_t addiv;

    checks = 0; fails = 0; cnt_model = 0;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    instr = 32'h0; pc = 32'h0; rs1_data = 32'h0; rs2_data = 32'h0;

    // R-type
    add_legal  (32'h002081B3, 32'h0, 32'd5,        32'd7,  4'h0, 32'd5,        32'd7,        5'd3);
    add_legal  (32'h40C58533, 32'h0, 32'd100,      32'd30, 4'h1, 32'd100,      32'd30,       5'd10);
    add_legal  (32'h0020F033, 32'h0, 32'hF0F0F0F0, 32'hFF, 4'h2, 32'hF0F0F0F0, 32'hFF,       5'd0);
    add_legal  (32'h0020E233, 32'h0, 32'h1,        32'h2,  4'h3, 32'h1,        32'h2,        5'd4);
    add_legal  (32'h0020C233, 32'h0, 32'h3,        32'h4,  4'h4, 32'h3,        32'h4,        5'd4);
    add_legal  (32'h00209233, 32'h0, 32'h5,        32'h6,  4'h5, 32'h5,        32'h6,        5'd4);
    add_legal  (32'h0020D233, 32'h0, 32'h7,        32'h8,  4'h6, 32'h7,        32'h8,        5'd4);
    add_legal  (32'h4020D233, 32'h0, 32'h9,        32'hA,  4'h7, 32'h9,        32'hA,        5'd4);
    // I-type
    add_legal  (32'h40335293, 32'h0, 32'h80000000, 32'h55, 4'h7, 32'h80000000, 32'd3,        5'd5);
    add_legal  (32'hFFF00093, 32'h0, 32'h11,       32'h22, 4'h0, 32'h11,       32'hFFFFFFFF, 5'd1);
    add_legal  (32'h7FF0C113, 32'h0, 32'h12,       32'h0,  4'h4, 32'h12,       32'h7FF,      5'd2);
    add_legal  (32'h8000E113, 32'h0, 32'h13,       32'h0,  4'h3, 32'h13,       32'hFFFFF800, 5'd2);
    add_legal  (32'h0F00F113, 32'h0, 32'h14,       32'h0,  4'h2, 32'h14,       32'hF0,       5'd2);
    add_legal  (32'h01F09113, 32'h0, 32'h15,       32'h0,  4'h5, 32'h15,       32'd31,       5'd2);
    add_legal  (32'h0040D113, 32'h0, 32'h16,       32'h0,  4'h6, 32'h16,       32'd4,        5'd2);
    // illegal: slt, mul-style funct7, slli with bad funct7, slti, store
    add_illegal(32'h003120B3, 32'h0, 32'h1, 32'h2, 5'd1);
    add_illegal(32'h022081B3, 32'h0, 32'h1, 32'h2, 5'd3);
    add_illegal(32'h40109113, 32'h0, 32'h1, 32'h2, 5'd2);
    add_illegal(32'h0010A113, 32'h0, 32'h1, 32'h2, 5'd2);
    add_illegal(32'h0020A023, 32'h0, 32'h1, 32'h2, 5'd0);
`ifdef ALU_DEC_UTYPE_EN
    add_legal  (32'h123450B7, 32'h100, 32'h77, 32'h88, 4'h8, 32'h0,   32'h12345000, 5'd1);
    add_legal  (32'hABCDE297, 32'h200, 32'h77, 32'h88, 4'h0, 32'h200, 32'hABCDE000, 5'd5);
`else
    add_illegal(32'h123450B7, 32'h100, 32'h77, 32'h88, 5'd1);
    add_illegal(32'hABCDE297, 32'h200, 32'h77, 32'h88, 5'd5);
`endif
    addv  = vecs[0];
    addiv = vecs[9];
    sltv  = vecs[15];

    // Reset values while rst is held
    #3;
    chk("reset_payload", actual(), pk(1'b0, 4'h0, 32'h0, 32'h0, 5'd0, 1'b0));
    chk("reset_valid", W'(out_valid), W'(0));
    chk("reset_cnt", W'(illegal_cnt), W'(0));
    @(negedge clk);
    rst = 1'b0;

    // Pass 1: downstream always ready, back-to-back with no stalls
    foreach (vecs[k]) begin
      send(vecs[k], 1, 1'b0, w);
      chk($sformatf("no_stall_%0d", k), W'(w), W'(0));
    end
    drain();
    chk("cnt_after_table", W'(illegal_cnt), W'(cnt_model));

    // Pass 2: random backpressure
    for (int r = 0; r < 2; r++) begin
      foreach (vecs[k]) send(vecs[k], 2, 1'b0, w);
    end
    drain();
    chk("cnt_after_random", W'(illegal_cnt), W'(cnt_model));

    // Hold under backpressure: payload frozen, in_ready low for 3 cycles
    send(addiv, 0, 1'b0, w);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      instr = 32'h0020C233; in_valid = 1'b1; out_ready = 1'b0;
      #1;
      chk($sformatf("hold_in_ready_%0d", c), W'(in_ready), W'(0));
      chk($sformatf("hold_valid_%0d", c), W'(out_valid), W'(1));
      chk($sformatf("hold_payload_%0d", c), actual(), addiv.exp);
    end
    @(negedge clk);
    in_valid = 1'b0;
    drain();

    // Illegal count saturation
    for (int n = 0; n < 300; n++) send(sltv, 1, 1'b0, w);
    drain();
    chk("cnt_saturated", W'(illegal_cnt), W'(255));

    // Flush with a held result and a simultaneous illegal accept
    send(addv, 0, 1'b0, w);
    @(negedge clk);
    instr = sltv.instr; rs1_data = 32'h1; rs2_data = 32'h2;
    in_valid = 1'b1; flush = 1'b1; out_ready = 1'b0;
    #1;
    chk("flush_in_ready", W'(in_ready), W'(1));
    void'(exp_q.pop_front());
    @(posedge clk);
    #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_valid", W'(out_valid), W'(0));
    chk("flush_cnt", W'(illegal_cnt), W'(255));

    // Asynchronous reset while a result is held
    send(addv, 0, 1'b0, w);
    @(negedge clk);
    #3;
    chk("pre_rst_valid", W'(out_valid), W'(1));
    rst = 1'b1;
    #1;
    chk("async_rst_valid", W'(out_valid), W'(0));
    chk("async_rst_cnt", W'(illegal_cnt), W'(0));
    chk("async_rst_payload", actual(), pk(1'b0, 4'h0, 32'h0, 32'h0, 5'd0, 1'b0));
    exp_q.delete();
    cnt_model = 0;

    // First accept on the first edge after reset release
    @(negedge clk);
    rst = 1'b0;
    v = vecs[1];
    instr = v.instr; pc = v.pc; rs1_data = v.rs1; rs2_data = v.rs2;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("post_rst_ready", W'(in_ready), W'(1));
    exp_q.push_back(v.exp);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("post_rst_valid", W'(out_valid), W'(1));
    drain();

    chk("final_queue_empty", W'(exp_q.size()), W'(0));
    chk("final_cnt", W'(illegal_cnt), W'(cnt_model));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/alu_decode_stage.md
ALU_DECODE_STAGE -- requirements
Module: alu_decode_stage

Interface
REQ-001 SHALL have parameter UNUSED_NONE: no parameters; all widths fixed (XLEN 32).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  instruction/operands present; in_ready  output  1  stage accepts.
REQ-005 instr  input  32  RV32I instruction; pc  input  32  its address; rs1_data, rs2_data  input  32  register operands.
REQ-006 flush  input  1  synchronous kill of held and incoming instruction.
REQ-007 out_valid  output  1  registered result valid; out_ready  input  1  ALU/EX stage accepts.
REQ-008 alu_a, alu_b  output  32  ALU operands; alu_op  output  4  ALU op code; rd  output  5; reg_write  output  1; illegal  output  1.
REQ-009 illegal_cnt  output  8  saturating count of illegal instructions accepted.

Function
REQ-010 alu_op encoding SHALL be: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 sll, 0110 srl, 0111 sra, 1000 pass-b.
REQ-011 in_ready SHALL equal (!out_valid | out_ready | flush); accept = in_valid & in_ready.
REQ-012 On accept without flush, all output registers SHALL load decoded values next edge and out_valid SHALL be 1 (latency 1 cycle).
REQ-013 Without accept, if out_ready then out_valid SHALL clear; otherwise outputs SHALL hold unchanged (no payload change while out_valid & !out_ready).
REQ-014 flush SHALL clear out_valid next edge, discard any simultaneous accept, and not change illegal_cnt; flush overrides accept.
REQ-015 R-type (0110011), funct7 0000000: f3 000 add, 001 sll, 100 xor, 101 srl, 110 or, 111 and; funct7 0100000: f3 000 sub, 101 sra; a=rs1_data, b=rs2_data.
REQ-016 I-type (0010011): addi/xori/ori/andi -> add/xor/or/and, b = sign-extended instr[31:20]; slli (funct7 0) / srli (funct7 0) / srai (funct7 0100000) -> b = {27'b0, instr[24:20]}; a=rs1_data.
REQ-017 Any other opcode/funct combination (incl. slt/sltu/slti/sltiu, bad funct7) SHALL decode illegal: illegal=1, alu_op=0000, alu_a=alu_b=0, reg_write=0.
REQ-018 rd = instr[11:7]; reg_write = legal & (rd != 0).
REQ-019 illegal_cnt SHALL increment on each non-flushed accept of an illegal instruction, saturating at 255.
REQ-020 Simultaneous accept and out_ready SHALL load the new instruction (back-to-back throughput 1/cycle, no bubble).

Reset
REQ-021 rst SHALL immediately force out_valid=0, alu_a=alu_b=0, alu_op=0000, rd=0, reg_write=0, illegal=0, illegal_cnt=0, regardless of clk.
REQ-022 First accept SHALL be possible on the first rising edge after rst deasserts; rst mid-transfer SHALL drop the held instruction.

Configuration
REQ-023 Macro ALU_DEC_UTYPE_EN defined: LUI (0110111) -> alu_op 1000, a=0, b={instr[31:12],12'b0}; AUIPC (0010111) -> alu_op 0000, a=pc, b={instr[31:12],12'b0}.
REQ-024 ALU_DEC_UTYPE_EN undefined: LUI and AUIPC SHALL decode illegal per REQ-017.

Verification
REQ-025 instr=0x002081B3, rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, alu_op=0000, a=5, b=7, rd=3, reg_write=1.
REQ-026 instr=0x40335293 (srai x5,x6,3), rs1=0x80000000 -> alu_op=0111, b=3, a=0x80000000, rd=5.
REQ-027 instr=0xFFF00093 (addi x1,x0,-1) -> alu_op=0000, b=0xFFFFFFFF; with out_ready=0 for 3 cycles outputs hold and in_ready=0.
REQ-028 instr=0x003120B3 (slt) accepted 300 times -> illegal=1, reg_write=0 each, illegal_cnt=255 at end; accept with flush=1 -> out_valid=0 next cycle, count unchanged.
REQ-029 instr=0x123450B7 (lui x1,0x12345), pc=0x100 -> with ALU_DEC_UTYPE_EN alu_op=1000, b=0x12345000; without it illegal=1.
REQ-030 rst asserted asynchronously while out_valid=1 and out_ready=0 -> out_valid=0 and illegal_cnt=0 before next clk edge.
